// File: rtl/enc_out_stage_pkg.sv
// Shared encoder constants and the output-stage state type.
// Beat counts are derived from the code geometry and must divide exactly.
package enc_out_stage_pkg;

    localparam int ENC_SYM         = 4;
    localparam int EGF_DIM         = 8;
    localparam int ENC_MES_BUF_DEP = 8;
    localparam int ENC_MES_LEN     = 16;
    localparam int ENC_PAR_LEN     = 8;

    localparam int ENC_MES_BEATS = ENC_MES_LEN / ENC_SYM;
    localparam int ENC_PAR_BEATS = ENC_PAR_LEN / ENC_SYM;

    localparam int ENC_MAX_BEATS = (ENC_MES_BEATS > ENC_PAR_BEATS) ? ENC_MES_BEATS : ENC_PAR_BEATS;
    localparam int ENC_CNT_W     = (ENC_MAX_BEATS > 1) ? $clog2(ENC_MAX_BEATS) : 1;

    typedef enum logic {
        MES = 1'b0,
        PAR = 1'b1
    } enc_out_state_t;

endpackage

// File: rtl/enc_out_stage.sv
// Encoder output stage: streams the message beats of a codeword, then the
// parity snapshot, through one registered valid/ready output port.
module enc_out_stage
    import enc_out_stage_pkg::*;
(
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    con_stall,
    input  logic [ENC_MES_BUF_DEP-1:0][EGF_DIM-1:0] mes_buf_data,
    input  logic                                    mes_valid,
    input  logic                                    par_load,
    input  logic [ENC_PAR_LEN-1:0][EGF_DIM-1:0]     par_data,
    input  logic                                    out_ready,
    output logic [ENC_SYM-1:0][EGF_DIM-1:0]         out_data,
    output logic                                    out_valid,
    output logic                                    out_last,
    output logic                                    stall_req,
    output logic                                    par_ovf
);

    if ((ENC_MES_LEN % ENC_SYM) != 0) begin : g_bad_mes_len
        $error("ENC_MES_LEN must be a multiple of ENC_SYM");
    end
    if ((ENC_PAR_LEN % ENC_SYM) != 0) begin : g_bad_par_len
        $error("ENC_PAR_LEN must be a multiple of ENC_SYM");
    end

    // Only the tail beat of the message buffer is consumed here.
    if (ENC_MES_BUF_DEP > ENC_SYM) begin : g_head
        logic unused_head;
        assign unused_head = ^mes_buf_data[ENC_MES_BUF_DEP-ENC_SYM-1:0];
    end

    enc_out_state_t                      state;
    logic [ENC_CNT_W-1:0]                cnt;
    logic                                par_full;
    logic [ENC_PAR_LEN-1:0][EGF_DIM-1:0] snap;
    logic                                ld;
    logic                                mes_take;
    logic                                par_rd;
    logic                                par_last_rd;

    // Handshake: a beat transfers on a rising edge where out_valid && out_ready;
    // once out_valid is high, out_data/out_last hold until that transfer.
    assign ld          = !out_valid || out_ready;
    assign stall_req   = out_valid && !out_ready;
    assign mes_take    = (state == MES) && ld && mes_valid && !con_stall;
    assign par_rd      = (state == PAR) && ld && par_full;
    assign par_last_rd = par_rd && (cnt == ENC_CNT_W'(ENC_PAR_BEATS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= MES;
            cnt       <= '0;
            par_full  <= 1'b0;
            par_ovf   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            snap      <= '0;
        end else begin
            if (ld) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                case (state)
                    MES: begin
                        if (mes_take) begin
                            out_data  <= mes_buf_data[ENC_MES_BUF_DEP-1 -: ENC_SYM];
                            out_valid <= 1'b1;
                            if (cnt == ENC_CNT_W'(ENC_MES_BEATS - 1)) begin
                                cnt   <= '0;
                                state <= PAR;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    PAR: begin
                        if (par_full) begin
                            out_data  <= snap[ENC_PAR_LEN-1 -: ENC_SYM];
                            out_valid <= 1'b1;
                            if (par_last_rd) begin
                                out_last <= 1'b1;
                                cnt      <= '0;
                                state    <= MES;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= MES;
                endcase
            end

            // A load landing on the final parity read refills rather than overruns.
            if (par_load && (!par_full || par_last_rd)) begin
                snap     <= par_data;
                par_full <= 1'b1;
            end else begin
                if (par_load) begin
                    par_ovf <= 1'b1;
                end
                if (par_rd) begin
                    snap <= snap << (ENC_SYM * EGF_DIM);
                    if (par_last_rd) begin
                        par_full <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_enc_out_stage.sv
// Directed bench for enc_out_stage: the bench plays controller, message
// source, parity source and sink; accepted beats are checked against exp_q.
module tb_enc_out_stage;
    import enc_out_stage_pkg::*;

    localparam int W = ENC_SYM * EGF_DIM + 1;

    logic                                    clk;
    logic                                    rst_n;
    logic                                    con_stall;
    logic [ENC_MES_BUF_DEP-1:0][EGF_DIM-1:0] mes_buf_data;
    logic                                    mes_valid;
    logic                                    par_load;
    logic [ENC_PAR_LEN-1:0][EGF_DIM-1:0]     par_data;
    logic                                    out_ready;
    logic [ENC_SYM-1:0][EGF_DIM-1:0]         out_data;
    logic                                    out_valid;
    logic                                    out_last;
    logic                                    stall_req;
    logic                                    par_ovf;

    logic           ctrl_hold;
    logic [W-1:0]   exp_q[$];
    logic [W-1:0]   exp_w;
    int             n_cmp = 0;
    int             n_bad = 0;
    int             cyc = 0;
    int             acc_cnt = 0;
    int             acc_first = 0;
    int             acc_last = 0;
    int             stall_cnt = 0;
    int             drv_start = 0;
    int             bp_left = 0;
    logic           bp_arm = 1'b0;
    logic           bp_chk = 1'b0;
    logic [W-2:0]   bp_word = '0;

    // The bench acts as the controller: sink backpressure folds into con_stall.
    assign con_stall = stall_req | ctrl_hold;

    enc_out_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .con_stall    (con_stall),
        .mes_buf_data (mes_buf_data),
        .mes_valid    (mes_valid),
        .par_load     (par_load),
        .par_data     (par_data),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_last     (out_last),
        .stall_req    (stall_req),
        .par_ovf      (par_ovf)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_par(input logic [7:0] pbase);
        par_load = 1'b1;
        for (int i = 0; i < ENC_PAR_LEN; i++) par_data[i] = pbase + 8'(i);
    endtask

    task automatic clear_par();
        par_load = 1'b0;
        for (int i = 0; i < ENC_PAR_LEN; i++) par_data[i] = 8'h5A ^ 8'(i * 3);
    endtask

    task automatic send_mes(input logic [7:0] base, input logic par_now,
                            input logic [7:0] pbase, input int hold_beat);
        for (int b = 0; b < ENC_MES_BEATS; b++) begin
            logic took;
            int   tries;
            took  = 1'b0;
            tries = 0;
            for (int j = 0; j < ENC_MES_BUF_DEP; j++) mes_buf_data[j] = 8'hEE;
            for (int j = 0; j < ENC_SYM; j++) mes_buf_data[ENC_MES_BUF_DEP-1-j] = base + 8'(ENC_SYM * b + j);
            mes_valid = 1'b1;
            while (!took && tries < 40) begin
                if (b == 0 && tries == 0) drv_start = cyc;
                if (b == ENC_MES_BEATS - 1 && par_now && tries == 0) set_par(pbase);
                ctrl_hold = (b == hold_beat) && (tries == 0);
                @(negedge clk);
                took = !con_stall;
                step();
                clear_par();
                ctrl_hold = 1'b0;
                tries++;
            end
            if (!took) check_eq("mes_accept", took, 1);
        end
        mes_valid = 1'b0;
    endtask

    task automatic idle(input int n, input int par_at, input logic [7:0] pbase, input logic hold);
        mes_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            ctrl_hold = hold;
            if (i == par_at) set_par(pbase);
            step();
            clear_par();
        end
        ctrl_hold = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    task automatic push_cw(input logic [7:0] base, input logic [7:0] pbase, input logic with_par);
        logic [W-1:0] w;
        for (int b = 0; b < ENC_MES_BEATS; b++) begin
            w = '0;
            for (int j = 0; j < ENC_SYM; j++) w[EGF_DIM*(ENC_SYM-1-j) +: EGF_DIM] = base + 8'(ENC_SYM * b + j);
            exp_q.push_back(w);
        end
        if (with_par) begin
            for (int k = 0; k < ENC_PAR_BEATS; k++) begin
                w = '0;
                for (int j = 0; j < ENC_SYM; j++)
                    w[EGF_DIM*(ENC_SYM-1-j) +: EGF_DIM] = pbase + 8'(ENC_PAR_LEN - 1 - ENC_SYM * k - j);
                w[W-1] = (k == ENC_PAR_BEATS - 1);
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic stats_clear();
        acc_cnt   = 0;
        acc_first = 0;
        acc_last  = 0;
        stall_cnt = 0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                acc_cnt++;
                if (acc_cnt == 1) acc_first = cyc;
                acc_last = cyc;
                check_eq("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    exp_w = exp_q.pop_front();
                    check_eq("beat", {out_last, out_data}, exp_w);
                end
            end
            if (rst_n && stall_req) begin
                stall_cnt++;
                if (bp_chk) check_eq("bp_hold", out_data, bp_word);
            end
        end
    end

    // Sink: ready except for a 3-cycle hold armed on a chosen beat.
    initial begin
        out_ready = 1'b1;
        forever begin
            step();
            if (bp_left > 0) begin
                out_ready = 1'b0;
                bp_left--;
            end else if (bp_arm && out_valid && out_data == bp_word) begin
                out_ready = 1'b0;
                bp_left   = 2;
                bp_arm    = 1'b0;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n        = 1'b0;
        mes_valid    = 1'b0;
        mes_buf_data = '0;
        ctrl_hold    = 1'b0;
        clear_par();

        @(posedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_last", out_last, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_stall_req", stall_req, 0);
        check_eq("rst_par_ovf", par_ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Nominal codeword, parity on time
        stats_clear();
        push_cw(8'h01, 8'hA1, 1'b1);
        send_mes(8'h01, 1'b1, 8'hA1, -1);
        idle(6, -1, 8'h00, 1'b0);
        check_eq("nom_beats", acc_cnt, 6);
        check_eq("nom_gaps", acc_last - acc_first + 1 - acc_cnt, 0);
        check_eq("nom_latency", acc_first - drv_start, 1);
        check_eq("nom_drained", exp_q.size(), 0);
        check_eq("nom_idle_valid", out_valid, 0);
        check_eq("nom_idle_last", out_last, 0);
        check_eq("nom_ovf", par_ovf, 0);

        // Sink backpressure on beat 2, controller stall on beat 1
        stats_clear();
        bp_word = 32'h292A2B2C;
        bp_arm  = 1'b1;
        bp_chk  = 1'b1;
        push_cw(8'h21, 8'hB1, 1'b1);
        send_mes(8'h21, 1'b1, 8'hB1, 1);
        idle(8, -1, 8'h00, 1'b0);
        bp_chk = 1'b0;
        check_eq("bp_stall_cycles", stall_cnt, 3);
        check_eq("bp_beats", acc_cnt, 6);
        check_eq("bp_drained", exp_q.size(), 0);

        // Late parity, controller stalled while parity drains
        stats_clear();
        push_cw(8'h41, 8'hC1, 1'b1);
        send_mes(8'h41, 1'b0, 8'h00, -1);
        idle(8, 1, 8'hC1, 1'b1);
        check_eq("late_beats", acc_cnt, 6);
        check_eq("late_gaps", acc_last - acc_first + 1 - acc_cnt, 2);
        check_eq("late_drained", exp_q.size(), 0);

        // Back-to-back codewords, next parity loaded on the last parity read
        stats_clear();
        push_cw(8'h61, 8'hD1, 1'b1);
        push_cw(8'h71, 8'hE1, 1'b1);
        send_mes(8'h61, 1'b1, 8'hD1, -1);
        idle(ENC_PAR_BEATS, 1, 8'hE1, 1'b0);
        send_mes(8'h71, 1'b0, 8'h00, -1);
        idle(6, -1, 8'h00, 1'b0);
        check_eq("b2b_beats", acc_cnt, 12);
        check_eq("b2b_gaps", acc_last - acc_first + 1 - acc_cnt, 0);
        check_eq("b2b_ovf", par_ovf, 0);
        check_eq("b2b_drained", exp_q.size(), 0);

        // Overrun: second load during drain is dropped and flagged
        stats_clear();
        push_cw(8'h81, 8'hF1, 1'b1);
        send_mes(8'h81, 1'b1, 8'hF1, -1);
        idle(6, 0, 8'h11, 1'b0);
        check_eq("ovf_set", par_ovf, 1);
        check_eq("ovf_drained", exp_q.size(), 0);
        push_cw(8'h91, 8'h31, 1'b1);
        send_mes(8'h91, 1'b1, 8'h31, -1);
        idle(6, -1, 8'h00, 1'b0);
        check_eq("ovf_sticky", par_ovf, 1);
        check_eq("ovf_next_drained", exp_q.size(), 0);

        // Reset during parity beat 0
        stats_clear();
        push_cw(8'hB1, 8'h51, 1'b0);
        send_mes(8'hB1, 1'b1, 8'h51, -1);
        step();
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_last", out_last, 0);
        check_eq("mid_rst_data", out_data, 0);
        check_eq("mid_rst_stall", stall_req, 0);
        check_eq("mid_rst_ovf", par_ovf, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step();
        check_eq("mid_rst_mes_seen", exp_q.size(), 0);
        stats_clear();
        push_cw(8'hC1, 8'h61, 1'b1);
        send_mes(8'hC1, 1'b1, 8'h61, -1);
        idle(6, -1, 8'h00, 1'b0);
        check_eq("post_rst_beats", acc_cnt, 6);
        check_eq("post_rst_gaps", acc_last - acc_first + 1 - acc_cnt, 0);
        check_eq("post_rst_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/enc_out_stage.md
ENC_OUT_STAGE -- requirements
Module: enc_out_stage

Interface
REQ-001 Parameters SHALL come from encoder.vh: ENC_SYM (symbols per beat), EGF_DIM (bits per GF symbol), ENC_MES_BUF_DEP (message buffer depth), ENC_MES_LEN (K), ENC_PAR_LEN (N-K).
REQ-002 Derived constants: ENC_MES_BEATS = ENC_MES_LEN/ENC_SYM; ENC_PAR_BEATS = ENC_PAR_LEN/ENC_SYM; both SHALL be exact integers, and this SHALL be checked at elaboration.
REQ-003 Ports SHALL be:
  clk  input  1  rising-edge clock
  rst_n  input  1  asynchronous active-low reset
  con_stall  input  1  controller stall; high = message pipeline frozen
  mes_buf_data  input  [ENC_MES_BUF_DEP][EGF_DIM]  message buffer contents; tail beat = indices ENC_MES_BUF_DEP-1 down to ENC_MES_BUF_DEP-ENC_SYM
  mes_valid  input  1  tail beat holds a valid message beat
  par_load  input  1  one-cycle pulse: par_data is the final parity of the current codeword
  par_data  input  [ENC_PAR_LEN][EGF_DIM]  parity; index ENC_PAR_LEN-1 is the highest degree
  out_ready  input  1  sink accepts out_data this cycle
  out_data  output  [ENC_SYM][EGF_DIM]  codeword beat; index ENC_SYM-1 is the first symbol
  out_valid  output  1  out_data valid
  out_last  output  1  final beat of the codeword
  stall_req  output  1  out_valid && !out_ready (combinational); the controller folds it into con_stall
  par_ovf  output  1  sticky parity-overrun error

Function
REQ-004 Output register load enable SHALL be ld = !out_valid || out_ready.
REQ-005 FSM states SHALL be MES and PAR, with MES as the reset state; the beat counter SHALL be cnt, sized for max(ENC_MES_BEATS, ENC_PAR_BEATS).
REQ-006 In MES, when ld && mes_valid && !con_stall, the block SHALL:
  - register the tail beat into out_data in index order;
  - set out_valid=1 and out_last=0;
  - increment cnt.
REQ-007 In MES, when the beat captured under REQ-006 is beat ENC_MES_BEATS-1, the block SHALL clear cnt and go to PAR.
REQ-008 A par_load pulse SHALL copy par_data into a snapshot register and set par_full, in either state.
REQ-009 A par_load pulse while par_full=1 SHALL set par_ovf and SHALL NOT disturb the snapshot.
REQ-010 In PAR, when ld && par_full, the block SHALL:
  - output the top ENC_SYM snapshot symbols;
  - shift the snapshot up by ENC_SYM;
  - set out_valid=1 and increment cnt.
  con_stall SHALL NOT gate this transfer.
REQ-011 In PAR, when ld && !par_full, out_valid SHALL go to 0 and the block SHALL wait; this is a parity-late bubble.
REQ-012 In PAR, beat ENC_PAR_BEATS-1 SHALL set out_last=1, clear par_full, clear cnt and return to MES.
REQ-013 When par_load coincides with the last parity read, par_full SHALL end at 1 with the new snapshot; this is not an overrun.
REQ-014 When ld is high and no beat is produced, out_valid and out_last SHALL go to 0.
REQ-015 When ld is low, out_data, out_valid and out_last SHALL hold, independent of con_stall.
REQ-016 Latency SHALL be one cycle from a beat being accepted to it appearing on out_data.
REQ-017 Back-to-back operation: the first message beat of the next codeword SHALL be accepted the cycle after out_last is accepted; sustained throughput SHALL be 1 beat/cycle with no bubbles when par_load is on time.

Reset
REQ-018 When rst_n=0, the block SHALL asynchronously set: state=MES, cnt=0, par_full=0, par_ovf=0, out_valid=0, out_last=0, out_data='0, snapshot='0.
REQ-019 Reset mid-codeword SHALL discard the partial codeword; the first beat after reset release SHALL be treated as message beat 0.
REQ-020 par_ovf SHALL be cleared only by reset.

Structure
REQ-021 ENC_MES_BEATS, ENC_PAR_BEATS and the state enum type (enc_out_state_t) SHALL live in the shared encoder package/header.
REQ-022 The block SHALL be a single module with no sub-modules; the parity snapshot shifter SHALL be inline.

Verification (ENC_SYM=4, EGF_DIM=8, K=16, N-K=8, so 4 message beats + 2 parity beats)
REQ-023 Nominal case: 4 message beats with symbols 0x01..0x10 in consecutive cycles, par_load with parity 0xA1..0xA8 on beat 3, out_ready=1.
  Required: 6 consecutive valid beats; beat 4 = A8,A7,A6,A5; beat 5 = A4..A1 with out_last=1.
REQ-024 Sink backpressure: out_ready=0 for 3 cycles on beat 2.
  Required: stall_req=1 for 3 cycles; out_data stable; no beat lost or duplicated.
REQ-025 Late parity: par_load arrives 2 cycles after message beat 3.
  Required: out_valid=0 for 2 cycles, then both parity beats.
REQ-026 Overrun: second par_load before parity drain.
  Required: par_ovf=1 and sticky; first parity output unchanged.
REQ-027 Boundary: back-to-back codewords with par_load coinciding with the last parity read.
  Required: 12 beats with no bubble; par_ovf=0.
REQ-028 Reset: rst_n low during parity beat 0.
  Required: all outputs 0 immediately; the next 4 accepted beats are treated as message beats.
